// File: rtl/rs_station_multi.sv
// Reservation station for the ALU/branch path: captures operands from NUM_CDB broadcast
// channels and issues the oldest ready entry through a one-deep valid/ready register.
module rs_station_multi #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ROB_W   = 4,
  parameter int unsigned OP_W    = 6,
  parameter int unsigned NUM_CDB = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      rollback,
  input  logic                      disp_valid,
  input  logic [OP_W-1:0]           disp_op,
  input  logic [DATA_W-1:0]         disp_v1,
  input  logic [DATA_W-1:0]         disp_v2,
  input  logic [ROB_W-1:0]          disp_q1,
  input  logic [ROB_W-1:0]          disp_q2,
  input  logic                      disp_q1_wait,
  input  logic                      disp_q2_wait,
  input  logic [DATA_W-1:0]         disp_pc,
  input  logic [DATA_W-1:0]         disp_imm,
  input  logic [ROB_W-1:0]          disp_rob,
  input  logic [NUM_CDB-1:0]        cdb_valid,
  input  logic [NUM_CDB*ROB_W-1:0]  cdb_rob,
  input  logic [NUM_CDB*DATA_W-1:0] cdb_data,
  output logic                      iss_valid,
  input  logic                      iss_ready,
  output logic [OP_W-1:0]           iss_op,
  output logic [DATA_W-1:0]         iss_v1,
  output logic [DATA_W-1:0]         iss_v2,
  output logic [DATA_W-1:0]         iss_pc,
  output logic [DATA_W-1:0]         iss_imm,
  output logic [ROB_W-1:0]          iss_rob,
  output logic                      full,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0]  busy_q, w1_q, w2_q, busy_d, ready;
  logic [DEPTH-1:0]  age_q [DEPTH];
  logic [DEPTH-1:0]  age_d [DEPTH];
  logic [OP_W-1:0]   op_q  [DEPTH];
  logic [DATA_W-1:0] v1_q  [DEPTH];
  logic [DATA_W-1:0] v2_q  [DEPTH];
  logic [DATA_W-1:0] pc_q  [DEPTH];
  logic [DATA_W-1:0] imm_q [DEPTH];
  logic [ROB_W-1:0]  q1_q  [DEPTH];
  logic [ROB_W-1:0]  q2_q  [DEPTH];
  logic [ROB_W-1:0]  rob_q [DEPTH];

  // {hit, data}; lowest matching channel wins
  logic [DATA_W:0]   hit1 [DEPTH];
  logic [DATA_W:0]   hit2 [DEPTH];
  logic [DATA_W:0]   dhit1, dhit2;

  logic              have_pick, have_free, pop_en, pop, alloc;
  logic [IDX_W-1:0]  pick_idx, free_idx;

  function automatic logic [DATA_W:0] cdb_lookup(input logic [ROB_W-1:0] tag,
                                                 input logic [NUM_CDB-1:0] vld,
                                                 input logic [NUM_CDB*ROB_W-1:0] tags,
                                                 input logic [NUM_CDB*DATA_W-1:0] data);
    cdb_lookup = '0;
    for (int k = NUM_CDB - 1; k >= 0; k--) begin
      if (vld[k] && tags[k*ROB_W +: ROB_W] == tag) cdb_lookup = {1'b1, data[k*DATA_W +: DATA_W]};
    end
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      hit1[i] = cdb_lookup(q1_q[i], cdb_valid, cdb_rob, cdb_data);
      hit2[i] = cdb_lookup(q2_q[i], cdb_valid, cdb_rob, cdb_data);
    end
    dhit1 = cdb_lookup(disp_q1, cdb_valid, cdb_rob, cdb_data);
    dhit2 = cdb_lookup(disp_q2, cdb_valid, cdb_rob, cdb_data);
  end

  // age_q[i][j] set means entry j is older than entry i
  always_comb begin
    ready     = busy_q & ~w1_q & ~w2_q;
    have_pick = 1'b0;
    pick_idx  = '0;
    have_free = 1'b0;
    free_idx  = '0;
    count     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i] && ((age_q[i] & ready) == '0)) begin
        have_pick = 1'b1;
        pick_idx  = IDX_W'(i);
      end
      count = count + {{IDX_W{1'b0}}, busy_q[i]};
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        have_free = 1'b1;
        free_idx  = IDX_W'(i);
      end
    end
  end

  assign full   = ~have_free;
  assign pop_en = ~iss_valid | iss_ready;
  assign pop    = pop_en & have_pick;
  assign alloc  = disp_valid & have_free;

  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < DEPTH; i++) age_d[i] = age_q[i];
    if (alloc) begin
      busy_d[free_idx] = 1'b1;
      age_d[free_idx]  = busy_q;
    end
    if (pop) begin
      busy_d[pick_idx] = 1'b0;
      for (int i = 0; i < DEPTH; i++) age_d[i][pick_idx] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || rollback) begin
      busy_q    <= '0;
      w1_q      <= '0;
      w2_q      <= '0;
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
      iss_valid <= 1'b0;
      iss_op    <= '0;
      iss_v1    <= '0;
      iss_v2    <= '0;
      iss_pc    <= '0;
      iss_imm   <= '0;
      iss_rob   <= '0;
    end else if (rdy) begin
      busy_q <= busy_d;
      for (int i = 0; i < DEPTH; i++) begin
        age_q[i] <= age_d[i];
        if (busy_q[i] && w1_q[i] && hit1[i][DATA_W]) begin
          w1_q[i] <= 1'b0;
          v1_q[i] <= hit1[i][DATA_W-1:0];
        end
        if (busy_q[i] && w2_q[i] && hit2[i][DATA_W]) begin
          w2_q[i] <= 1'b0;
          v2_q[i] <= hit2[i][DATA_W-1:0];
        end
      end
      // The allocated slot was free, so it never collides with a wakeup above
      if (alloc) begin
        op_q[free_idx]  <= disp_op;
        q1_q[free_idx]  <= disp_q1;
        q2_q[free_idx]  <= disp_q2;
        w1_q[free_idx]  <= disp_q1_wait & ~dhit1[DATA_W];
        w2_q[free_idx]  <= disp_q2_wait & ~dhit2[DATA_W];
        v1_q[free_idx]  <= (disp_q1_wait && dhit1[DATA_W]) ? dhit1[DATA_W-1:0] : disp_v1;
        v2_q[free_idx]  <= (disp_q2_wait && dhit2[DATA_W]) ? dhit2[DATA_W-1:0] : disp_v2;
        pc_q[free_idx]  <= disp_pc;
        imm_q[free_idx] <= disp_imm;
        rob_q[free_idx] <= disp_rob;
      end
      if (pop_en) begin
        iss_valid <= have_pick;
        if (have_pick) begin
          iss_op  <= op_q[pick_idx];
          iss_v1  <= v1_q[pick_idx];
          iss_v2  <= v2_q[pick_idx];
          iss_pc  <= pc_q[pick_idx];
          iss_imm <= imm_q[pick_idx];
          iss_rob <= rob_q[pick_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_station_multi.sv
// Random and directed stimulus for rs_station_multi, checked every cycle against a
// slot/sequence-number reference model.
module tb_rs_station_multi;

  localparam int DEPTH = 16, DATA_W = 32, ROB_W = 4, OP_W = 6, NUM_CDB = 2;

  logic clk, rst, rdy, rollback, disp_valid, disp_q1_wait, disp_q2_wait, iss_ready;
  logic [OP_W-1:0]           disp_op;
  logic [DATA_W-1:0]         disp_v1, disp_v2, disp_pc, disp_imm;
  logic [ROB_W-1:0]          disp_q1, disp_q2, disp_rob;
  logic [NUM_CDB-1:0]        cdb_valid;
  logic [NUM_CDB*ROB_W-1:0]  cdb_rob;
  logic [NUM_CDB*DATA_W-1:0] cdb_data;
  logic                      iss_valid, full;
  logic [OP_W-1:0]           iss_op;
  logic [DATA_W-1:0]         iss_v1, iss_v2, iss_pc, iss_imm;
  logic [ROB_W-1:0]          iss_rob;
  logic [$clog2(DEPTH):0]    count;

  rs_station_multi #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .ROB_W(ROB_W), .OP_W(OP_W), .NUM_CDB(NUM_CDB)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .disp_valid(disp_valid), .disp_op(disp_op), .disp_v1(disp_v1), .disp_v2(disp_v2),
    .disp_q1(disp_q1), .disp_q2(disp_q2), .disp_q1_wait(disp_q1_wait),
    .disp_q2_wait(disp_q2_wait), .disp_pc(disp_pc), .disp_imm(disp_imm),
    .disp_rob(disp_rob), .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_data(cdb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op), .iss_v1(iss_v1),
    .iss_v2(iss_v2), .iss_pc(iss_pc), .iss_imm(iss_imm), .iss_rob(iss_rob),
    .full(full), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: slots plus a dispatch sequence number for age
  bit                m_busy [DEPTH];
  bit                m_w1   [DEPTH];
  bit                m_w2   [DEPTH];
  logic [ROB_W-1:0]  m_q1   [DEPTH];
  logic [ROB_W-1:0]  m_q2   [DEPTH];
  logic [ROB_W-1:0]  m_rob  [DEPTH];
  logic [OP_W-1:0]   m_op   [DEPTH];
  logic [DATA_W-1:0] m_v1   [DEPTH];
  logic [DATA_W-1:0] m_v2   [DEPTH];
  logic [DATA_W-1:0] m_pc   [DEPTH];
  logic [DATA_W-1:0] m_imm  [DEPTH];
  int unsigned       m_seq  [DEPTH];
  int unsigned       seq_ctr = 0;
  bit                e_valid;
  logic [OP_W-1:0]   e_op;
  logic [DATA_W-1:0] e_v1, e_v2, e_pc, e_imm;
  logic [ROB_W-1:0]  e_rob;
  int                n_checks = 0;
  int                n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cdb_find(input logic [ROB_W-1:0] tag, output bit hit,
                          output logic [DATA_W-1:0] d);
    hit = 0;
    d   = '0;
    for (int k = 0; k < NUM_CDB; k++) begin
      if (!hit && cdb_valid[k] && cdb_rob[k*ROB_W +: ROB_W] == tag) begin
        hit = 1;
        d   = cdb_data[k*DATA_W +: DATA_W];
      end
    end
  endtask

  task automatic model_edge();
    int pick, slot;
    bit h;
    logic [DATA_W-1:0] d;
    if (rst || rollback) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_busy[i] = 0; m_w1[i] = 0; m_w2[i] = 0;
      end
      e_valid = 0; e_op = '0; e_v1 = '0; e_v2 = '0; e_pc = '0; e_imm = '0; e_rob = '0;
      return;
    end
    if (!rdy) return;
    pick = -1;
    slot = -1;
    for (int i = 0; i < DEPTH; i++)
      if (m_busy[i] && !m_w1[i] && !m_w2[i] && (pick < 0 || m_seq[i] < m_seq[pick])) pick = i;
    for (int i = DEPTH - 1; i >= 0; i--) if (!m_busy[i]) slot = i;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_busy[i] && m_w1[i]) begin
        cdb_find(m_q1[i], h, d);
        if (h) begin m_w1[i] = 0; m_v1[i] = d; end
      end
      if (m_busy[i] && m_w2[i]) begin
        cdb_find(m_q2[i], h, d);
        if (h) begin m_w2[i] = 0; m_v2[i] = d; end
      end
    end
    if (!e_valid || iss_ready) begin
      e_valid = (pick >= 0);
      if (pick >= 0) begin
        e_op = m_op[pick]; e_v1 = m_v1[pick]; e_v2 = m_v2[pick];
        e_pc = m_pc[pick]; e_imm = m_imm[pick]; e_rob = m_rob[pick];
        m_busy[pick] = 0;
      end
    end
    if (disp_valid && slot >= 0) begin
      m_busy[slot] = 1; m_op[slot] = disp_op; m_pc[slot] = disp_pc; m_imm[slot] = disp_imm;
      m_rob[slot] = disp_rob; m_q1[slot] = disp_q1; m_q2[slot] = disp_q2;
      m_seq[slot] = seq_ctr++;
      m_v1[slot] = disp_v1; m_w1[slot] = disp_q1_wait;
      m_v2[slot] = disp_v2; m_w2[slot] = disp_q2_wait;
      if (disp_q1_wait) begin
        cdb_find(disp_q1, h, d);
        if (h) begin m_w1[slot] = 0; m_v1[slot] = d; end
      end
      if (disp_q2_wait) begin
        cdb_find(disp_q2, h, d);
        if (h) begin m_w2[slot] = 0; m_v2[slot] = d; end
      end
    end
  endtask

  task automatic step();
    int cnt;
    @(posedge clk);
    model_edge();
    #1;
    cnt = 0;
    for (int i = 0; i < DEPTH; i++) if (m_busy[i]) cnt++;
    check_eq("iss_valid", 64'(iss_valid), 64'(e_valid));
    check_eq("count", 64'(count), 64'(cnt));
    check_eq("full", 64'(full), 64'(cnt == DEPTH));
    if (e_valid) begin
      check_eq("iss_rob", 64'(iss_rob), 64'(e_rob));
      check_eq("iss_op", 64'(iss_op), 64'(e_op));
      check_eq("iss_v1", 64'(iss_v1), 64'(e_v1));
      check_eq("iss_v2", 64'(iss_v2), 64'(e_v2));
      check_eq("iss_pc", 64'(iss_pc), 64'(e_pc));
      check_eq("iss_imm", 64'(iss_imm), 64'(e_imm));
    end
  endtask

  task automatic idle();
    rst = 0; rdy = 1; rollback = 0; disp_valid = 0; cdb_valid = '0;
  endtask

  task automatic disp(input int rob, input bit w1, input int q1, input bit w2, input int q2);
    disp_valid = 1; disp_rob = ROB_W'(rob); disp_op = OP_W'($urandom);
    disp_v1 = $urandom; disp_v2 = $urandom; disp_pc = $urandom; disp_imm = $urandom;
    disp_q1_wait = w1; disp_q1 = ROB_W'(q1); disp_q2_wait = w2; disp_q2 = ROB_W'(q2);
  endtask

  task automatic cdb(input int ch, input int tag, input logic [DATA_W-1:0] d);
    cdb_valid[ch] = 1'b1;
    cdb_rob[ch*ROB_W +: ROB_W] = ROB_W'(tag);
    cdb_data[ch*DATA_W +: DATA_W] = d;
  endtask

  initial begin
    idle();
    rst = 1; iss_ready = 1; cdb_rob = '0; cdb_data = '0;
    disp(0, 0, 0, 0, 0);
    disp_valid = 1;
    step();
    check_eq("rst_iss_valid", 64'(iss_valid), 64'd0);
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_full", 64'(full), 64'd0);
    check_eq("rst_iss_rob", 64'(iss_rob), 64'd0);
    check_eq("rst_iss_v1", 64'(iss_v1), 64'd0);

    // three ready ops back to back
    for (int r = 1; r <= 3; r++) begin idle(); disp(r, 0, 0, 0, 0); step(); end
    idle(); repeat (4) step();

    // late operand via channel 1; younger ready op overtakes
    idle(); disp(5, 1, 9, 0, 0); step();
    disp(6, 0, 0, 0, 0); step();
    idle(); cdb(1, 9, 32'hDEAD); step();
    idle(); repeat (4) step();

    // dispatch-time bypass
    idle(); disp(7, 0, 0, 1, 4); cdb(0, 4, 32'h55); step();
    idle(); repeat (3) step();

    // fill while stalled, drop extras, then drain
    iss_ready = 0;
    for (int i = 0; i < DEPTH + 3; i++) begin idle(); disp(i, 0, 0, 0, 0); step(); end
    check_eq("fill_full", 64'(full), 64'd1);
    idle(); iss_ready = 1; repeat (DEPTH + 3) step();

    // oldest-first: rob10 lands in slot 3, rob11 later reuses slot 0
    iss_ready = 0;
    idle(); disp(1, 0, 0, 0, 0); step();
    disp(2, 1, 2, 0, 0); step();
    disp(3, 1, 2, 0, 0); step();
    disp(4, 1, 7, 0, 0); step();
    disp(10, 0, 0, 0, 0); step();
    idle(); cdb(0, 2, 32'h1234); step();
    idle(); iss_ready = 1; step(); step();
    iss_ready = 0; disp(11, 0, 0, 0, 0); step();
    idle(); iss_ready = 1; step();
    check_eq("oldest_first", 64'(iss_rob), 64'd10);
    repeat (3) step();

    // rollback with pending entries and a held issue
    iss_ready = 0;
    for (int i = 0; i < 5; i++) begin idle(); disp(i, 0, 0, 1, 3); step(); end
    disp(12, 0, 0, 0, 0); step();
    idle(); rollback = 1; cdb(0, 3, 32'h77); disp(13, 0, 0, 0, 0); step();
    check_eq("rb_count", 64'(count), 64'd0);
    check_eq("rb_iss_valid", 64'(iss_valid), 64'd0);
    check_eq("rb_full", 64'(full), 64'd0);
    idle(); iss_ready = 1; cdb(0, 3, 32'h77); step(); step();

    // random phases with varying back-pressure
    for (int ph = 0; ph < 3; ph++) begin
      for (int n = 0; n < 1500; n++) begin
        rst = ($urandom_range(999) == 0);
        rollback = ($urandom_range(249) == 0);
        rdy = ($urandom_range(9) != 0);
        iss_ready = ($urandom_range(99) < (ph == 0 ? 25 : (ph == 1 ? 70 : 100)));
        disp_valid = 0;
        if ($urandom_range(99) < 55)
          disp($urandom_range(15), $urandom_range(99) < 40, $urandom_range(7),
               $urandom_range(99) < 40, $urandom_range(7));
        for (int k = 0; k < NUM_CDB; k++) begin
          cdb_valid[k] = ($urandom_range(99) < 30);
          cdb_rob[k*ROB_W +: ROB_W] = ROB_W'($urandom_range(7));
          cdb_data[k*DATA_W +: DATA_W] = $urandom;
        end
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
